// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning chain.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat timing).
package btn_pkg;

  // Per-channel press FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Pair indices: pair k drives channel 2k (up) and 2k+1 (down)
  localparam int P_S  = 0;
  localparam int P_M  = 1;
  localparam int P_H  = 2;
  localparam int P_D  = 3;
  localparam int P_MO = 4;
  localparam int P_Y  = 5;

  // Bits needed for a counter that runs from 0 to n-1 (never less than 1)
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button line: two-flop synchronizer, stability-count debouncer and
// press FSM. The pulse output is combinational; the top registers it.
// Optional feature macro: BTN_AUTOREPEAT_EN (adds HELD timer and REPEAT).
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse_o,
  output logic deb_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject configurations that would break the single-cycle pulse guarantee
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_channel: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("btn_channel: REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("btn_channel: REPEAT_PERIOD must be at least 2");
  end

  logic           sync_meta_q;
  logic           sync_q;
  logic           deb_q, deb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  btn_state_e     state_q, state_d;
  logic           pulse_d;

  // Two-flop synchronizer for the asynchronous raw line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= btn_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // Debouncer: accept a new level only after an unbroken run of differing samples
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int TW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] tmr_q, tmr_d;

  // Press FSM with hold-to-repeat; release wins over a same-cycle expiry
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    if (!deb_q) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse_d = 1'b1;
          state_d = HELD;
          tmr_d   = '0;
        end
        HELD: begin
          if (tmr_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            state_d = REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        REPEAT: begin
          if (tmr_q == PERIOD_LAST) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // FSM and repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end
`else
  // Press FSM without repeat: HELD is terminal until the button is released
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    if (!deb_q) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      pulse_d = 1'b1;
      state_d = HELD;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  assign pulse_o = pulse_d;
  assign deb_o   = deb_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions 2*N_PAIR raw push-button lines into clean single-cycle pulses
// for the clock's up/down set inputs. Pair k owns channel 2k (up) and
// 2k+1 (down); pairs are ordered s, m, h, d, mo, y.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_PAIR          = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*N_PAIR-1:0]   btn_raw,
  output logic [2*N_PAIR-1:0]   pulse_o,
  output logic [2*N_PAIR-1:0]   level_o
);

  localparam int NCH = 2 * N_PAIR;

  logic [NCH-1:0] raw_pulse;
  logic [NCH-1:0] deb;
  logic [NCH-1:0] pulse_q, pulse_d;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[ch]),
      .pulse_o (raw_pulse[ch]),
      .deb_o   (deb[ch])
    );
  end

  // Pair interlock: up and down held together emit nothing; FSMs keep running
  always_comb begin
    pulse_d = raw_pulse;
    for (int p = 0; p < N_PAIR; p++) begin
      if (deb[2*p] && deb[2*p+1]) begin
        pulse_d[2*p]   = 1'b0;
        pulse_d[2*p+1] = 1'b0;
      end
    end
  end

  // Output pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  // The debounced level is already a flop output inside each channel
  assign level_o = deb;

endmodule
